// File: rtl/dac_spi_driver.sv
// Dual-channel SPI DAC driver: shifts two 16-bit command words (channel A then B),
// then pulses LDAC so both DAC outputs update together.
module dac_spi_driver #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        ds_en_i,
    input  logic        ds_start_i,
    input  logic [11:0] ds_ch1_i,
    input  logic [11:0] ds_ch2_i,
    output logic        ds_sck_o,
    output logic        ds_sdi_o,
    output logic        ds_cs_n_o,
    output logic        ds_ldac_n_o,
    output logic        ds_busy_o,
    output logic        ds_done_o,
    output logic [7:0]  ds_drop_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRAME_A,
        S_GAP_A,
        S_FRAME_B,
        S_GAP_B,
        S_LDAC,
        S_DONE
    } state_t;

    // Within a frame: sck-low half, sck-high half, and the closing hold after bit 0.
    typedef enum logic [1:0] {
        PH_LO,
        PH_HI,
        PH_TAIL
    } phase_t;

    localparam logic [7:0] HALF_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(CS_GAP - 1);

    state_t      state_reg, state_next;
    phase_t      phase_reg, phase_next;
    logic [7:0]  hcnt_reg, hcnt_next;
    logic [3:0]  bcnt_reg, bcnt_next;
    logic [15:0] shift_reg, shift_next;
    logic [11:0] ch2_reg, ch2_next;
    logic [7:0]  drop_reg, drop_next;

    logic sck_reg, sdi_reg, cs_n_reg, ldac_n_reg, busy_reg, done_reg;
    logic sck_next, sdi_next, cs_n_next, ldac_n_next, busy_next, done_next;
    logic in_frame_next;

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        hcnt_next  = hcnt_reg;
        bcnt_next  = bcnt_reg;
        shift_next = shift_reg;
        ch2_next   = ch2_reg;
        drop_next  = drop_reg;

        // Any start that finds the engine busy is lost and counted (saturating).
        if (ds_start_i && ds_en_i && (state_reg != S_IDLE) && (drop_reg != 8'hFF))
            drop_next = drop_reg + 8'd1;

        case (state_reg)
            S_IDLE: begin
                if (ds_start_i && ds_en_i) begin
                    state_next = S_FRAME_A;
                    phase_next = PH_LO;
                    hcnt_next  = HALF_LOAD;
                    bcnt_next  = 4'd15;
                    shift_next = {1'b0, 3'b111, ds_ch1_i};
                    ch2_next   = ds_ch2_i;
                end
            end
            S_FRAME_A, S_FRAME_B: begin
                if (hcnt_reg != 8'd0) begin
                    hcnt_next = hcnt_reg - 8'd1;
                end else begin
                    hcnt_next = HALF_LOAD;
                    case (phase_reg)
                        PH_LO: phase_next = PH_HI;
                        PH_HI: begin
                            // Advance data on the falling sck so it is stable at the next rise.
                            if (bcnt_reg == 4'd0) begin
                                phase_next = PH_TAIL;
                            end else begin
                                phase_next = PH_LO;
                                bcnt_next  = bcnt_reg - 4'd1;
                                shift_next = {shift_reg[14:0], 1'b0};
                            end
                        end
                        default: begin
                            state_next = (state_reg == S_FRAME_A) ? S_GAP_A : S_GAP_B;
                            hcnt_next  = GAP_LOAD;
                        end
                    endcase
                end
            end
            S_GAP_A: begin
                if (hcnt_reg != 8'd0) begin
                    hcnt_next = hcnt_reg - 8'd1;
                end else begin
                    state_next = S_FRAME_B;
                    phase_next = PH_LO;
                    hcnt_next  = HALF_LOAD;
                    bcnt_next  = 4'd15;
                    shift_next = {1'b1, 3'b111, ch2_reg};
                end
            end
            S_GAP_B: begin
                if (hcnt_reg != 8'd0) begin
                    hcnt_next = hcnt_reg - 8'd1;
                end else begin
                    state_next = S_LDAC;
                    hcnt_next  = HALF_LOAD;
                end
            end
            S_LDAC: begin
                if (hcnt_reg != 8'd0) hcnt_next = hcnt_reg - 8'd1;
                else                  state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Pin values are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        in_frame_next = (state_next == S_FRAME_A) || (state_next == S_FRAME_B);
        sck_next      = in_frame_next && (phase_next == PH_HI);
        sdi_next      = in_frame_next ? shift_next[15] : 1'b0;
        cs_n_next     = !in_frame_next;
        ldac_n_next   = (state_next != S_LDAC);
        busy_next     = (state_next != S_IDLE);
        done_next     = (state_next == S_DONE);
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_reg  <= S_IDLE;
            phase_reg  <= PH_LO;
            hcnt_reg   <= 8'd0;
            bcnt_reg   <= 4'd0;
            shift_reg  <= 16'd0;
            ch2_reg    <= 12'd0;
            drop_reg   <= 8'd0;
            sck_reg    <= 1'b0;
            sdi_reg    <= 1'b0;
            cs_n_reg   <= 1'b1;
            ldac_n_reg <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            phase_reg  <= phase_next;
            hcnt_reg   <= hcnt_next;
            bcnt_reg   <= bcnt_next;
            shift_reg  <= shift_next;
            ch2_reg    <= ch2_next;
            drop_reg   <= drop_next;
            sck_reg    <= sck_next;
            sdi_reg    <= sdi_next;
            cs_n_reg   <= cs_n_next;
            ldac_n_reg <= ldac_n_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign ds_sck_o      = sck_reg;
    assign ds_sdi_o      = sdi_reg;
    assign ds_cs_n_o     = cs_n_reg;
    assign ds_ldac_n_o   = ldac_n_reg;
    assign ds_busy_o     = busy_reg;
    assign ds_done_o     = done_reg;
    assign ds_drop_cnt_o = drop_reg;

endmodule

// File: tb/tb_dac_spi_driver.sv
// Bench for dac_spi_driver: three instances (4/2, 1/1, 8/2 dividers/gaps), an SPI
// monitor that decodes frames, and directed vectors with hand-computed words and latencies.
module tb_dac_spi_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic [11:0] ch1 = 12'd0;
    logic [11:0] ch2 = 12'd0;
    logic        start [3] = '{1'b0, 1'b0, 1'b0};
    logic        sck [3], sdi [3], cs_n [3], ldac_n [3], busy [3], done [3];
    logic [7:0]  drop [3];

    dac_spi_driver #(.CLK_DIV(4), .CS_GAP(2)) u_def (
        .sys_clk_i(clk), .sys_rst_i(rst_n), .ds_en_i(en), .ds_start_i(start[0]),
        .ds_ch1_i(ch1), .ds_ch2_i(ch2), .ds_sck_o(sck[0]), .ds_sdi_o(sdi[0]),
        .ds_cs_n_o(cs_n[0]), .ds_ldac_n_o(ldac_n[0]), .ds_busy_o(busy[0]),
        .ds_done_o(done[0]), .ds_drop_cnt_o(drop[0]));

    dac_spi_driver #(.CLK_DIV(1), .CS_GAP(1)) u_fast (
        .sys_clk_i(clk), .sys_rst_i(rst_n), .ds_en_i(en), .ds_start_i(start[1]),
        .ds_ch1_i(ch1), .ds_ch2_i(ch2), .ds_sck_o(sck[1]), .ds_sdi_o(sdi[1]),
        .ds_cs_n_o(cs_n[1]), .ds_ldac_n_o(ldac_n[1]), .ds_busy_o(busy[1]),
        .ds_done_o(done[1]), .ds_drop_cnt_o(drop[1]));

    dac_spi_driver #(.CLK_DIV(8), .CS_GAP(2)) u_slow (
        .sys_clk_i(clk), .sys_rst_i(rst_n), .ds_en_i(en), .ds_start_i(start[2]),
        .ds_ch1_i(ch1), .ds_ch2_i(ch2), .ds_sck_o(sck[2]), .ds_sdi_o(sdi[2]),
        .ds_cs_n_o(cs_n[2]), .ds_ldac_n_o(ldac_n[2]), .ds_busy_o(busy[2]),
        .ds_done_o(done[2]), .ds_drop_cnt_o(drop[2]));

    int divs [3] = '{4, 1, 8};
    int gapc [3] = '{2, 1, 2};

    // ---------------- SPI monitor (samples on falling clk edge) ----------------
    logic        prev_sck [3] = '{1'b0, 1'b0, 1'b0};
    logic        prev_sdi [3] = '{1'b0, 1'b0, 1'b0};
    logic        prev_cs  [3] = '{1'b1, 1'b1, 1'b1};
    logic        prev_ld  [3] = '{1'b1, 1'b1, 1'b1};
    logic [15:0] cap      [3] = '{16'd0, 16'd0, 16'd0};
    int          cap_bits [3] = '{default: 0};
    int          hi_run   [3] = '{default: 0};
    int          cs_run   [3] = '{default: 0};
    int          ld_run   [3] = '{default: 0};
    int          fin_txn  [3] = '{default: 0};
    logic [15:0] words    [3][64];
    int          wbits    [3][64];
    int          nfrm     [3] = '{default: 0};
    int          gaps     [3][32];
    int          ngap     [3] = '{default: 0};
    int          ldl      [3][32];
    int          nldac    [3] = '{default: 0};
    int          sck_bad  [3] = '{default: 0};
    int          sdi_bad  [3] = '{default: 0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                cap_bits[i] <= 0;
                hi_run[i]   <= 0;
                cs_run[i]   <= 0;
                ld_run[i]   <= 0;
                fin_txn[i]  <= 0;
            end else begin
                if (sck[i]) begin
                    hi_run[i] <= hi_run[i] + 1;
                    if (prev_sck[i] && (sdi[i] != prev_sdi[i])) sdi_bad[i] <= sdi_bad[i] + 1;
                    if (!prev_sck[i]) begin
                        cap[i]      <= {cap[i][14:0], sdi[i]};
                        cap_bits[i] <= cap_bits[i] + 1;
                    end
                end else if (prev_sck[i]) begin
                    if (hi_run[i] != divs[i]) sck_bad[i] <= sck_bad[i] + 1;
                    hi_run[i] <= 0;
                end
                if (!busy[i]) fin_txn[i] <= 0;
                if (cs_n[i]) begin
                    cs_run[i] <= cs_run[i] + 1;
                    if (!prev_cs[i]) begin
                        words[i][nfrm[i] % 64] <= cap[i];
                        wbits[i][nfrm[i] % 64] <= cap_bits[i];
                        nfrm[i]     <= nfrm[i] + 1;
                        cap_bits[i] <= 0;
                        fin_txn[i]  <= fin_txn[i] + 1;
                    end
                end else if (prev_cs[i]) begin
                    if (fin_txn[i] == 1) begin
                        gaps[i][ngap[i] % 32] <= cs_run[i];
                        ngap[i] <= ngap[i] + 1;
                    end
                    cs_run[i] <= 0;
                end
                if (!ldac_n[i]) begin
                    ld_run[i] <= ld_run[i] + 1;
                end else if (!prev_ld[i]) begin
                    ldl[i][nldac[i] % 32] <= ld_run[i];
                    nldac[i] <= nldac[i] + 1;
                    ld_run[i] <= 0;
                end
            end
            prev_sck[i] <= sck[i];
            prev_sdi[i] <= sdi[i];
            prev_cs[i]  <= cs_n[i];
            prev_ld[i]  <= ldac_n[i];
        end
    end

    // ---------------- checking helpers ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
    endtask

    // Returns cycles from the accepting edge to the cycle done is seen (done at N+lat).
    task automatic wait_done(input int i, output int lat);
        lat = 1;
        forever begin
            @(negedge clk);
            if (done[i]) break;
            if (lat > 20000) begin
                lat = -1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input string tag, input int i, input logic [11:0] a, input logic [11:0] b,
                           input logic [15:0] wa, input logic [15:0] wb, input int exp_lat,
                           input bit drop_en);
        int base, lbase, gbase, sb, db, lat;
        base  = nfrm[i];
        lbase = nldac[i];
        gbase = ngap[i];
        sb    = sck_bad[i];
        db    = sdi_bad[i];
        ch1 = a;
        ch2 = b;
        pulse_start(i);
        ch1 = ~a;
        ch2 = ~b;
        if (drop_en) en = 1'b0;
        wait_done(i, lat);
        en = 1'b1;
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " frames"}, nfrm[i] - base, 2);
        chk({tag, " word A"}, words[i][base % 64], wa);
        chk({tag, " word B"}, words[i][(base + 1) % 64], wb);
        chk({tag, " sck rises A"}, wbits[i][base % 64], 16);
        chk({tag, " sck rises B"}, wbits[i][(base + 1) % 64], 16);
        chk({tag, " cs gap"}, (ngap[i] == gbase + 1) ? gaps[i][gbase % 32] : -1, gapc[i]);
        chk({tag, " ldac width"}, (nldac[i] == lbase + 1) ? ldl[i][lbase % 32] : -1, divs[i]);
        chk({tag, " sck high width errs"}, sck_bad[i] - sb, 0);
        chk({tag, " sdi change while sck high"}, sdi_bad[i] - db, 0);
        chk({tag, " busy after done"}, busy[i], 1'b0);
        $display("txn %s: inst %0d ch1=%03h ch2=%03h words=%04h/%04h latency=%0d",
                 tag, i, a, b, words[i][base % 64], words[i][(base + 1) % 64], lat);
    endtask

    typedef struct {
        logic [11:0] c1;
        logic [11:0] c2;
        logic [15:0] wa;
        logic [15:0] wb;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int viol, lat, first_done, d0, nl;

        vecs[0] = '{12'hABC, 12'h123, 16'h7ABC, 16'hF123};
        vecs[1] = '{12'hFFF, 12'h000, 16'h7FFF, 16'hF000};
        vecs[2] = '{12'h000, 12'hFFF, 16'h7000, 16'hFFFF};
        vecs[3] = '{12'h555, 12'hAAA, 16'h7555, 16'hFAAA};

        // Reset values while held in reset, then 100 idle cycles.
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset sck", sck[0], 1'b0);
        chk("reset sdi", sdi[0], 1'b0);
        chk("reset cs_n", cs_n[0], 1'b1);
        chk("reset ldac_n", ldac_n[0], 1'b1);
        chk("reset busy", busy[0], 1'b0);
        chk("reset done", done[0], 1'b0);
        chk("reset drop_cnt", drop[0], 8'd0);
        rst_n = 1'b1;
        viol = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                if (!cs_n[i] || !ldac_n[i] || sck[i] || busy[i] || done[i] || drop[i] != 8'd0)
                    viol++;
        end
        chk("idle 100 cycles", viol, 0);
        @(posedge clk); #1;
        $display("txn idle: 100 cycles after reset release observed");

        // Table-driven transactions at default settings.
        for (int v = 0; v < 4; v++)
            run_txn($sformatf("vec%0d", v), 0, vecs[v].c1, vecs[v].c2, vecs[v].wa, vecs[v].wb, 273, 1'b0);

        // Fastest divider, and en dropped mid-transaction.
        run_txn("fast", 1, 12'hFFF, 12'h000, 16'h7FFF, 16'hF000, 70, 1'b0);
        run_txn("fast en-drop", 1, 12'h9C3, 12'h3C9, 16'h79C3, 16'hF3C9, 70, 1'b1);

        // Starts at N, N+10, N+272, N+274: first and last accepted.
        d0 = drop[0];
        first_done = -1;
        ch1 = 12'h246;
        ch2 = 12'h8AC;
        for (int c = 0; c <= 274; c++) begin
            start[0] = (c == 0 || c == 10 || c == 272 || c == 274);
            @(negedge clk);
            if (done[0] && first_done < 0) first_done = c;
            @(posedge clk); #1;
        end
        start[0] = 1'b0;
        wait_done(0, lat);
        chk("multi first done", first_done, 273);
        chk("multi second latency", lat, 273);
        chk("multi drop delta", int'(drop[0]) - d0, 2);
        $display("txn multi-start: first done at +%0d, second latency %0d, drops %0d",
                 first_done, lat, int'(drop[0]) - d0);

        // Start coincident with done is dropped; the next cycle is accepted.
        d0 = drop[1];
        first_done = -1;
        for (int c = 0; c <= 71; c++) begin
            start[1] = (c == 0 || c == 70 || c == 71);
            @(negedge clk);
            if (done[1] && first_done < 0) first_done = c;
            @(posedge clk); #1;
        end
        start[1] = 1'b0;
        wait_done(1, lat);
        chk("coincident first done", first_done, 70);
        chk("coincident second latency", lat, 70);
        chk("coincident drop delta", int'(drop[1]) - d0, 1);
        $display("txn coincident: first done at +%0d, second latency %0d", first_done, lat);

        // 300 starts in one busy window saturate the drop counter.
        for (int c = 0; c <= 300; c++) begin
            start[2] = 1'b1;
            @(posedge clk); #1;
        end
        start[2] = 1'b0;
        chk("saturated drop_cnt", drop[2], 8'd255);
        wait_done(2, lat);
        chk("slow latency after flood", lat, 541 - 300);
        en = 1'b0;
        pulse_start(2);
        chk("en=0 start ignored busy", busy[2], 1'b0);
        chk("en=0 drop_cnt stays", drop[2], 8'd255);
        en = 1'b1;
        $display("txn saturate: drop_cnt=%0d latency-rest=%0d", drop[2], lat);

        // Reset inside frame B aborts cleanly; the next transaction is complete.
        ch1 = 12'hABC;
        ch2 = 12'h123;
        pulse_start(0);
        repeat (149) @(posedge clk);
        #1;
        chk("abort point in frame", cs_n[0], 1'b0);
        nl = nldac[0];
        rst_n = 1'b0;
        #1;
        chk("abort sck", sck[0], 1'b0);
        chk("abort sdi", sdi[0], 1'b0);
        chk("abort cs_n", cs_n[0], 1'b1);
        chk("abort ldac_n", ldac_n[0], 1'b1);
        chk("abort busy", busy[0], 1'b0);
        chk("abort drop_cnt", drop[0], 8'd0);
        ch1 = 12'h777;
        ch2 = 12'h888;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort no ldac pulse", nldac[0] - nl, 0);
        $display("txn abort: reset applied mid-frame");
        run_txn("post-abort", 0, 12'h3C5, 12'hA5A, 16'h73C5, 16'hFA5A, 273, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
